// File: rtl/per_spi_if.sv
// Data-bus slave port of the SPI peripheral: address, write data, strobes and registered read data.
interface per_spi_if;
   logic [15:0] addr_i;
   logic [31:0] wdata_i;
   logic [31:0] rdata_o;
   logic [1:0]  size_i;
   logic        rd_i;
   logic        wr_i;

   modport master (
      output addr_i, wdata_i, size_i, rd_i, wr_i,
      input  rdata_o
   );

   modport slave (
      input  addr_i, wdata_i, size_i, rd_i, wr_i,
      output rdata_o
   );
endinterface

// File: rtl/per_spi.sv
// Memory-mapped SPI master, mode 0, MSB first, 8-bit full duplex with programmable divider.
module per_spi (
   input  logic     clk_i,
   input  logic     reset_i,
   per_spi_if.slave bus,
   output logic     spi_sck_o,
   output logic     spi_mosi_o,
   input  logic     spi_miso_i,
   output logic     spi_cs_o
);

   typedef enum logic {
      IDLE,
      XFER
   } state_t;

   state_t state, state_n;

   logic [1:0] sel;
   logic       data_wr, data_rd, ctrl_wr;
   logic       start, hp_end, finish, busy;

   logic [7:0] div, div_lat, cnt;
   logic [3:0] hp;
   logic [7:0] tx, rx, rx_data;
   logic       cs, sck, done;

   logic       unused_bits;

   assign sel     = bus.addr_i[3:2];
   assign data_wr = bus.wr_i && (sel == 2'd0);
   assign data_rd = bus.rd_i && (sel == 2'd0);
   assign ctrl_wr = bus.wr_i && (sel == 2'd2);

   assign unused_bits = ^{bus.addr_i[15:4], bus.addr_i[1:0], bus.wdata_i[31:9], bus.size_i};

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) state <= IDLE;
      else         state <= state_n;
   end

   // A half-period ends when the cycle counter reaches the divider latched at start.
   always_comb begin
      state_n = state;
      start   = 1'b0;
      hp_end  = 1'b0;
      finish  = 1'b0;
      busy    = 1'b0;
      case (state)
         IDLE: begin
            if (data_wr) begin
               start   = 1'b1;
               state_n = XFER;
            end
         end
         XFER: begin
            busy = 1'b1;
            if (cnt == div_lat) begin
               hp_end = 1'b1;
               if (hp == 4'd15) begin
                  finish  = 1'b1;
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         div_lat <= 8'h07;
         cnt     <= '0;
         hp      <= '0;
         tx      <= '0;
         rx      <= '0;
         rx_data <= '0;
         sck     <= 1'b0;
      end else if (start) begin
         tx      <= bus.wdata_i[7:0];
         div_lat <= div;
         cnt     <= '0;
         hp      <= '0;
      end else if (busy) begin
         if (hp_end) begin
            cnt <= '0;
            hp  <= hp + 4'd1;
            if (!hp[0]) begin
               sck <= 1'b1;
               rx  <= {rx[6:0], spi_miso_i};
            end else begin
               sck <= 1'b0;
               if (!finish) tx <= {tx[6:0], 1'b0};
            end
            if (finish) rx_data <= rx;
         end else begin
            cnt <= cnt + 8'd1;
         end
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         div <= 8'h07;
         cs  <= 1'b1;
      end else if (ctrl_wr) begin
         div <= bus.wdata_i[7:0];
         cs  <= bus.wdata_i[8];
      end
   end

   // Completion wins over a clearing DATA access in the same cycle.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)                done <= 1'b0;
      else if (finish)            done <= 1'b1;
      else if (data_rd || start)  done <= 1'b0;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         bus.rdata_o <= '0;
      end else if (bus.rd_i) begin
         case (sel)
            2'd0:    bus.rdata_o <= {24'd0, rx_data};
            2'd1:    bus.rdata_o <= {30'd0, done, busy};
            2'd2:    bus.rdata_o <= {23'd0, cs, div};
            default: bus.rdata_o <= '0;
         endcase
      end
   end

   assign spi_sck_o  = sck;
   assign spi_mosi_o = (state == XFER) && tx[7];
   assign spi_cs_o   = cs;

endmodule

// File: tb/tb_per_spi.sv
// Directed bench for per_spi: register map, transfer timing, loopback and patterned MISO, reset and aliasing.
module tb_per_spi;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   per_spi_if bus();
   logic sck, mosi, miso, cs;

   per_spi dut (
      .clk_i      (clk),
      .reset_i    (rst),
      .bus        (bus),
      .spi_sck_o  (sck),
      .spi_mosi_o (mosi),
      .spi_miso_i (miso),
      .spi_cs_o   (cs)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // SCK edge log, sampled on the falling clock edge.
   int         n_rise = 0;
   int         n_fall = 0;
   int         rise_cyc [512];
   int         fall_cyc [512];
   logic       sck_q = 1'b0;
   logic [7:0] mosi_rec = '0;

   always @(negedge clk) begin
      if (sck && !sck_q) begin
         rise_cyc[n_rise] = cyc;
         n_rise++;
         mosi_rec = {mosi_rec[6:0], mosi};
      end
      if (!sck && sck_q) begin
         fall_cyc[n_fall] = cyc;
         n_fall++;
      end
      sck_q = sck;
   end

   // MISO source: loopback, or a pattern advanced one bit per observed SCK fall.
   logic       loop = 1'b1;
   logic [7:0] miso_pat = '0;
   int         fall_base = 0;
   int         idx;
   logic       miso_bit;

   always_comb begin
      idx      = n_fall - fall_base;
      miso_bit = (idx >= 0 && idx < 8) ? miso_pat[7 - idx] : 1'b0;
   end

   assign miso = loop ? mosi : miso_bit;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
      bus.addr_i  = a;
      bus.wdata_i = d;
      bus.wr_i    = 1'b1;
      @(posedge clk);
      #1;
      bus.wr_i    = 1'b0;
   endtask

   task automatic bus_read(input logic [15:0] a, output logic [31:0] d);
      bus.addr_i = a;
      bus.rd_i   = 1'b1;
      @(posedge clk);
      #1;
      bus.rd_i   = 1'b0;
      d = bus.rdata_o;
   endtask

   logic [31:0] d;
   int t0, rb, fb;

   initial begin
      bus.addr_i  = '0;
      bus.wdata_i = '0;
      bus.size_i  = 2'b10;
      bus.rd_i    = 1'b0;
      bus.wr_i    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      idle(2);

      // Reset state
      check("rst_sck", 32'(sck), 32'd0);
      check("rst_mosi", 32'(mosi), 32'd0);
      check("rst_cs", 32'(cs), 32'd1);
      check("rst_rdata", bus.rdata_o, 32'h0);
      bus_read(16'h4, d); check("rst_status", d, 32'h0);
      bus_read(16'h8, d); check("rst_ctrl", d, 32'h107);
      bus_read(16'h0, d); check("rst_data", d, 32'h0);

      // Loopback at DIV=0, 0xA5
      loop = 1'b1;
      bus_write(16'h8, 32'h100);
      rb = n_rise; fb = n_fall;
      bus_write(16'h0, 32'hA5);
      t0 = cyc;
      check("t1_mosi_bit7", 32'(mosi), 32'd1);
      idle(15);
      bus_read(16'h4, d); check("t1_busy_last", d, 32'h1);
      bus_read(16'h4, d); check("t1_done", d, 32'h2);
      check("t1_rises", 32'(n_rise - rb), 32'd8);
      check("t1_first_rise", 32'(rise_cyc[rb] - t0), 32'd1);
      check("t1_period", 32'(rise_cyc[rb + 1] - rise_cyc[rb]), 32'd2);
      check("t1_last_fall", 32'(fall_cyc[fb + 7] - t0), 32'd16);
      bus_read(16'h4, d); check("t1_done_sticky", d, 32'h2);
      bus_read(16'h0, d); check("t1_data", d, 32'hA5);
      bus_read(16'h4, d); check("t1_done_clr", d, 32'h0);

      // DIV=3, MISO pattern 0x3C, TX 0xFF
      bus_write(16'h8, 32'h103);
      loop = 1'b0;
      miso_pat = 8'h3C;
      fall_base = n_fall;
      rb = n_rise; fb = n_fall;
      bus_write(16'h0, 32'hFF);
      t0 = cyc;
      idle(63);
      bus_read(16'h4, d); check("t2_busy_last", d, 32'h1);
      bus_read(16'h4, d); check("t2_done", d, 32'h2);
      bus_read(16'h0, d); check("t2_data", d, 32'h3C);
      check("t2_rises", 32'(n_rise - rb), 32'd8);
      check("t2_first_rise", 32'(rise_cyc[rb] - t0), 32'd4);
      check("t2_high", 32'(fall_cyc[fb] - rise_cyc[rb]), 32'd4);
      check("t2_low", 32'(rise_cyc[rb + 1] - fall_cyc[fb]), 32'd4);
      check("t2_last_fall", 32'(fall_cyc[fb + 7] - t0), 32'd64);
      check("t2_mosi", 32'(mosi_rec), 32'hFF);

      // Busy rejection at DIV=0
      loop = 1'b1;
      bus_write(16'h8, 32'h100);
      rb = n_rise;
      bus_write(16'h0, 32'h11);
      idle(4);
      bus_write(16'h0, 32'h22);
      idle(15);
      check("t3_rises", 32'(n_rise - rb), 32'd8);
      check("t3_mosi", 32'(mosi_rec), 32'h11);
      bus_read(16'h4, d); check("t3_status", d, 32'h2);
      bus_read(16'h0, d); check("t3_data", d, 32'h11);

      // CTRL writes during a DIV=3 transfer
      bus_write(16'h8, 32'h103);
      rb = n_rise; fb = n_fall;
      bus_write(16'h0, 32'h96);
      t0 = cyc;
      idle(9);
      check("t4_cs_before", 32'(cs), 32'd1);
      bus_write(16'h8, 32'h000);
      check("t4_cs_after", 32'(cs), 32'd0);
      idle(55);
      check("t4_rises", 32'(n_rise - rb), 32'd8);
      check("t4_last_fall", 32'(fall_cyc[fb + 7] - t0), 32'd64);
      bus_read(16'h8, d); check("t4_ctrl", d, 32'h000);

      // Reset during hp 7 of a DIV=3 transfer
      bus_write(16'h8, 32'h003);
      bus_write(16'h0, 32'hC3);
      idle(29);
      check("t5_sck_hp7", 32'(sck), 32'd1);
      check("t5_cs_pre", 32'(cs), 32'd0);
      rst = 1'b1;
      #1;
      check("t5_sck_rst", 32'(sck), 32'd0);
      check("t5_mosi_rst", 32'(mosi), 32'd0);
      check("t5_cs_rst", 32'(cs), 32'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus_read(16'h4, d); check("t5_status", d, 32'h0);
      bus_read(16'h0, d); check("t5_data", d, 32'h0);
      bus_read(16'h8, d); check("t5_ctrl", d, 32'h107);
      bus_write(16'h0, 32'h5A);
      idle(127);
      bus_read(16'h4, d); check("t5_busy_last", d, 32'h1);
      bus_read(16'h4, d); check("t5_done", d, 32'h2);

      // Address decode edges
      bus_read(16'h14, d); check("t6_alias", d, 32'h2);
      bus_read(16'hC, d); check("t6_rsvd", d, 32'h0);
      bus_write(16'h4, 32'hFFFF_FFFF);
      bus_read(16'h4, d); check("t6_status_wr", d, 32'h2);
      bus_write(16'hC, 32'hFFFF_FFFF);
      bus_read(16'h8, d); check("t6_ctrl_keep", d, 32'h107);
      bus_read(16'h0, d); check("t6_data", d, 32'h5A);
      bus_read(16'h4, d); check("t6_clr", d, 32'h0);

      // DATA read on the completion edge: old value returned, DONE still set
      bus_write(16'h8, 32'h100);
      bus_write(16'h0, 32'h3C);
      idle(15);
      bus_read(16'h0, d); check("t7_data_old", d, 32'h5A);
      bus_read(16'h4, d); check("t7_done_wins", d, 32'h2);
      bus_read(16'h0, d); check("t7_data_new", d, 32'h3C);
      bus_read(16'h4, d); check("t7_clr", d, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/per_spi.md
# per_spi

Memory-mapped SPI master peripheral that attaches to one slave port of the data-bus multiplexer, alongside the UART, GPIO and timer peripherals. The core writes a byte to start a full-duplex 8-bit mode-0 transfer, polls status, and reads back the received byte. The block contains a programmable clock divider, a transfer state machine, shift registers and a sticky completion flag.

## Interface
- No parameters.
- clk_i  in  1  system clock; all logic on the rising edge
- reset_i  in  1  asynchronous, active-high reset
- addr_i  in  16  byte address within the peripheral window; only [3:2] decoded, so the window aliases every 16 bytes
- wdata_i  in  32  write data
- rdata_o  out  32  read data, registered
- size_i  in  2  access size; ignored, all registers are treated as word access
- rd_i  in  1  read strobe, one cycle per access
- wr_i  in  1  write strobe, one cycle per access
- spi_sck_o  out  1  serial clock, idle low
- spi_mosi_o  out  1  serial data out
- spi_miso_i  in  1  serial data in; no synchronizer, board timing guarantees setup
- spi_cs_o  out  1  chip select, driven directly from CTRL.CS

## Operation
- Register map (addr_i[3:2]):
  - 0x0 DATA
    - Write: if idle, load wdata_i[7:0] into the TX shift register and start a transfer. If busy, the write is ignored.
    - Read: [7:0] = last received byte, [31:8] = 0.
  - 0x4 STATUS (read-only): bit0 BUSY, bit1 DONE, others 0. Writes are ignored.
  - 0x8 CTRL (R/W): [7:0] DIV, [8] CS, others read 0.
  - 0xC: reads 0, writes ignored.
- DONE flag:
  - Set when a transfer completes.
  - Cleared by any DATA read or by an accepted DATA write.
  - If completion coincides with a clearing access in the same cycle, set wins.
- DIV is latched at transfer start; a CTRL write during a transfer changes CS immediately but not the running DIV.
- State machine: IDLE -> XFER -> IDLE.
  - XFER counts 16 half-periods (hp = 0..15), each DIV+1 clk cycles long.
  - Mode 0, MSB first: MOSI is valid before the first rising SCK edge.
  - End of even hp: SCK rises; spi_miso_i is shifted into the RX register LSB-first-in (so the first bit lands in bit7 after 8 samples).
  - End of odd hp, except hp 15: SCK falls; TX shifts left and MOSI presents the next bit.
  - End of hp 15: SCK falls, RX byte is committed to the DATA read register, BUSY=0, DONE=1, return to IDLE.
- MOSI:
  - In IDLE, MOSI = 0.
  - In XFER, MOSI = TX[7].
- CS is fully software-controlled; the block never toggles it.

## Timing
- Reset values:
  - spi_sck_o = 0, spi_mosi_o = 0, spi_cs_o = 1
  - rdata_o = 0, DIV = 0x07, DATA RX = 0x00, BUSY = 0, DONE = 0
- Reads: rdata_o is valid in the cycle after rd_i is sampled high, and holds until the next read. Read and write strobes are never asserted together (bus guarantee).
- Transfer start: a DATA write sampled at edge T0 gives:
  - BUSY = 1 and MOSI = bit7 from T0+1.
  - First SCK rise at T0+1+(DIV+1).
- BUSY stays high for exactly 16·(DIV+1) cycles. DONE and the new DATA value are visible from the same cycle BUSY falls.
- SCK period = 2·(DIV+1) clk cycles. DIV = 0 gives SCK = clk/2.
- Back-to-back transfers: a DATA write in the first idle cycle starts the next transfer. There is no minimum idle gap.
- Reset asserted mid-transfer: all state returns to reset values immediately (asynchronous). The partial RX byte is discarded and SCK is forced low at once.

## Test plan
- Loopback at DIV=0 (MISO tied to MOSI), write DATA=0xA5:
  - BUSY high for exactly 16 cycles.
  - 8 SCK pulses of 2-cycle period.
  - DATA reads 0xA5 and STATUS reads 0x2.
  - A following STATUS read returns 0x0 only after an intervening DATA read.
- DIV=3, MISO driven with 0x3C MSB-first (each bit changed after the falling edge), write DATA=0xFF:
  - BUSY lasts 64 cycles.
  - SCK high and low phases are 4 cycles each.
  - DATA reads 0x3C.
- Busy rejection:
  - Write DATA=0x11, then DATA=0x22 mid-transfer.
  - MOSI shifts 0x11 only, and no second transfer starts.
- Mid-transfer CTRL writes:
  - CTRL write of DIV=0 during a DIV=3 transfer: the transfer still takes 64 cycles.
  - CTRL write of CS=0 mid-transfer: spi_cs_o falls the next cycle.
  - CTRL readback = 0x000 | DIV.
- Reset mid-transfer at hp 7:
  - Next cycle: SCK=0, MOSI=0, CS=1, BUSY=0, DATA=0x00, CTRL=0x107.
  - A new transfer then completes normally.
- Address edges:
  - Read 0xC returns 0.
  - Read 0x14 aliases STATUS.
  - Write to STATUS has no effect.
  - Completion coinciding with a DATA read leaves DONE=1.
